// File: rtl/maxil_pkg.sv
// Shared types and constants for the AXI4-Lite master read engine.
package maxil_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } maxil_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MAXIL_ADDR_W      = 32;
    localparam int MAXIL_DATA_W      = 32;
    localparam int MAXIL_TIMEOUT_CYC = 256;
    localparam int MAXIL_CNT_W       = 16;

endpackage

// File: rtl/maxil_timeout_cnt.sv
// Saturating wait counter with synchronous clear and a sticky limit flag.
// LIMIT == 0 keeps the counter parked at zero so the flag never sets.
module maxil_timeout_cnt #(
    parameter int LIMIT = 256,
    parameter int W     = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic flag
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;
    logic         flag_q, flag_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != LIM))
            cnt_d = cnt_q + 1'b1;
        flag_d = flag_q | ((LIMIT != 0) && (cnt_d == LIM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/maxil_read_top.sv
// AXI4-Lite master read engine: one outstanding read, registered outputs,
// local alignment check, sticky response timeout and completion counter.
module maxil_read_top
    import maxil_pkg::*;
#(
    parameter int ADDR_W      = MAXIL_ADDR_W,
    parameter int DATA_W      = MAXIL_DATA_W,
    parameter int TIMEOUT_CYC = MAXIL_TIMEOUT_CYC,
    parameter int CNT_W       = MAXIL_CNT_W
) (
    input  logic              maxil_read_top_clk,
    input  logic              maxil_read_top_rst_n,
    input  logic              maxil_read_cmd_valid,
    output logic              maxil_read_cmd_ready,
    input  logic [ADDR_W-1:0] maxil_read_cmd_addr,
    input  logic [2:0]        maxil_read_cmd_prot,
    output logic              maxil_read_arvalid,
    input  logic              maxil_read_arready,
    output logic [ADDR_W-1:0] maxil_read_araddr,
    output logic [2:0]        maxil_read_arprot,
    input  logic              maxil_read_rvalid,
    output logic              maxil_read_rready,
    input  logic [DATA_W-1:0] maxil_read_rdata,
    input  logic [1:0]        maxil_read_rresp,
    output logic              maxil_read_rsp_valid,
    input  logic              maxil_read_rsp_ready,
    output logic [DATA_W-1:0] maxil_read_rsp_data,
    output logic [1:0]        maxil_read_rsp_resp,
    output logic              maxil_read_timeout,
    output logic [CNT_W-1:0]  maxil_read_txn_count
);

    localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic clk, rst_n;
    assign clk   = maxil_read_top_clk;
    assign rst_n = maxil_read_top_rst_n;

    maxil_state_e      state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [2:0]        arprot_q, arprot_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;
    logic              cmd_aligned;

    assign cmd_aligned = (maxil_read_cmd_addr[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (maxil_read_cmd_valid) state_d = cmd_aligned ? ST_ADDR : ST_RESP;
            ST_ADDR: if (maxil_read_arready)   state_d = ST_DATA;
            ST_DATA: if (maxil_read_rvalid)    state_d = ST_RESP;
            ST_RESP: if (maxil_read_rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so every port is a flop.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        arvalid_d   = (state_d == ST_ADDR);
        rready_d    = (state_d == ST_DATA);
        rsp_valid_d = (state_d == ST_RESP);
        araddr_d    = araddr_q;
        arprot_d    = arprot_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        txn_cnt_d   = txn_cnt_q;
        if (state_q == ST_IDLE && maxil_read_cmd_valid) begin
            if (cmd_aligned) begin
                araddr_d = maxil_read_cmd_addr;
                arprot_d = maxil_read_cmd_prot;
            end else begin
                rsp_data_d = '0;
                rsp_resp_d = RESP_SLVERR;
            end
        end
        if (state_q == ST_DATA && maxil_read_rvalid) begin
            rsp_data_d = maxil_read_rdata;
            rsp_resp_d = maxil_read_rresp;
        end
        if (state_q == ST_RESP && maxil_read_rsp_ready)
            txn_cnt_d = txn_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            araddr_q    <= '0;
            arprot_q    <= '0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= RESP_OKAY;
            txn_cnt_q   <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            araddr_q    <= araddr_d;
            arprot_q    <= arprot_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    maxil_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC),
        .W     (TO_W)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q == ST_IDLE) && (state_d == ST_ADDR)),
        .en    ((state_q == ST_ADDR) || (state_q == ST_DATA)),
        .flag  (maxil_read_timeout)
    );

    assign maxil_read_cmd_ready = cmd_ready_q;
    assign maxil_read_arvalid   = arvalid_q;
    assign maxil_read_rready    = rready_q;
    assign maxil_read_rsp_valid = rsp_valid_q;
    assign maxil_read_araddr    = araddr_q;
    assign maxil_read_arprot    = arprot_q;
    assign maxil_read_rsp_data  = rsp_data_q;
    assign maxil_read_rsp_resp  = rsp_resp_q;
    assign maxil_read_txn_count = txn_cnt_q;

endmodule

// File: tb/tb_maxil_read_top.sv
// Directed bench for maxil_read_top: cycle-exact slave/sink driving with a
// scoreboard of expected responses pushed at command time.
module tb_maxil_read_top;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_prot;
    logic          arvalid, arready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          rvalid, rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          timeout;
    logic [CW-1:0] txn_count;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    maxil_read_top #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4), .CNT_W(CW)
    ) dut (
        .maxil_read_top_clk   (clk),
        .maxil_read_top_rst_n (rst_n),
        .maxil_read_cmd_valid (cmd_valid),
        .maxil_read_cmd_ready (cmd_ready),
        .maxil_read_cmd_addr  (cmd_addr),
        .maxil_read_cmd_prot  (cmd_prot),
        .maxil_read_arvalid   (arvalid),
        .maxil_read_arready   (arready),
        .maxil_read_araddr    (araddr),
        .maxil_read_arprot    (arprot),
        .maxil_read_rvalid    (rvalid),
        .maxil_read_rready    (rready),
        .maxil_read_rdata     (rdata),
        .maxil_read_rresp     (rresp),
        .maxil_read_rsp_valid (rsp_valid),
        .maxil_read_rsp_ready (rsp_ready),
        .maxil_read_rsp_data  (rsp_data),
        .maxil_read_rsp_resp  (rsp_resp),
        .maxil_read_timeout   (timeout),
        .maxil_read_txn_count (txn_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_addr = '0; cmd_prot = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_arprot"}, arprot, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_resp"}, rsp_resp, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_txn_count"}, txn_count, 0);
    endtask

    // Asserts reset wherever the clock currently is; values must drop at once.
    task automatic apply_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = 0;
        tick();
        check_reset_vals({tag, "_post"});
    endtask

    // One complete read, checked cycle by cycle against the expected latency.
    task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [2:0] prot,
                           input int ar_wait, input int r_wait, input logic [DW-1:0] data,
                           input logic [1:0] resp, input int rsp_wait, input bit junk_r);
        exp_t e;
        bit   aligned;
        aligned = (addr[1:0] == 2'b00);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_prot = prot;
        if (aligned) begin
            e.data = data; e.resp = resp;
        end else begin
            e.data = '0; e.resp = 2'b10;
        end
        sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
        if (aligned) begin
            for (int i = 0; i <= ar_wait; i++) begin
                chk({tag, "_arvalid"}, arvalid, 1);
                chk({tag, "_araddr"}, araddr, addr);
                chk({tag, "_arprot"}, arprot, prot);
                chk({tag, "_rready_in_addr"}, rready, 0);
                arready = (i == ar_wait);
                rvalid  = junk_r;
                rdata   = 32'hBAD0_BAD0;
                rresp   = 2'b11;
                tick();
            end
            arready = 1'b0;
            for (int i = 0; i <= r_wait; i++) begin
                chk({tag, "_rready"}, rready, 1);
                chk({tag, "_arvalid_in_data"}, arvalid, 0);
                rvalid = (i == r_wait);
                rdata  = (i == r_wait) ? data : 32'hBAD1_BAD1;
                rresp  = (i == r_wait) ? resp : 2'b11;
                tick();
            end
            rvalid = 1'b0;
        end else begin
            chk({tag, "_no_arvalid"}, arvalid, 0);
        end
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) e = sb.pop_front();
        for (int i = 0; i <= rsp_wait; i++) begin
            chk({tag, "_rsp_valid"}, rsp_valid, 1);
            chk({tag, "_rsp_data"}, rsp_data, e.data);
            chk({tag, "_rsp_resp"}, rsp_resp, e.resp);
            chk({tag, "_cmd_ready_busy"}, cmd_ready, 0);
            chk({tag, "_arvalid_resp"}, arvalid, 0);
            chk({tag, "_rready_resp"}, rready, 0);
            rsp_ready = (i == rsp_wait);
            tick();
        end
        rsp_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_txn_count"}, txn_count, exp_cnt);
        chk({tag, "_rsp_done"}, rsp_valid, 0);
        chk({tag, "_cmd_ready_back"}, cmd_ready, 1);
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2;
        apply_reset("rst");

        do_read("zero_wait", 32'h0000_0010, 3'd0, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 0);
        chk("zero_wait_timeout", timeout, 0);
        do_read("misalign", 32'h0000_0013, 3'd1, 0, 0, 32'h0, 2'b00, 1, 0);
        do_read("r_wait", 32'h0000_0020, 3'd4, 0, 3, 32'hCAFE_F00D, 2'b11, 0, 0);

        apply_reset("rst_bp");
        do_read("ar_bp", 32'h0000_0100, 3'b010, 5, 0, 32'h1234_5678, 2'b01, 2, 1);

        apply_reset("rst_to");
        cmd_valid = 1'b1; cmd_addr = 32'h0000_0080; cmd_prot = 3'd0;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("to_arvalid", arvalid, 1);
            chk("to_flag", timeout, (k >= 5) ? 1 : 0);
            tick();
        end

        apply_reset("rst_mid_pre");
        do_read("pre_abort", 32'h0000_0030, 3'd0, 0, 0, 32'h0BAD_F00D, 2'b00, 0, 0);
        cmd_valid = 1'b1; cmd_addr = 32'h0000_0040; cmd_prot = 3'd5;
        tick();
        cmd_valid = 1'b0; arready = 1'b1;
        chk("abort_arvalid", arvalid, 1);
        tick();
        arready = 1'b0;
        chk("abort_in_data", rready, 1);
        #2;
        apply_reset("rst_mid");
        do_read("post_abort", 32'h0000_0044, 3'd2, 1, 1, 32'hA5A5_5A5A, 2'b00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
